// File: rtl/pipe_pkg.sv
// Shared types for the RV32 pipeline sequencer: forwarding selects, sequencer states
// and the register-match helper used by both the stall and forwarding logic.
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } hctl_state_e;

  // x0 is hardwired zero, so it never produces a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> sequencer bundle. The datapath drives through 'master'; hazard_ctrl uses 'slave'.
// HAZ_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              id_use_rs1, id_use_rs2;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_mem_read;
  logic [REG_AW-1:0] exm_rd;
  logic              exm_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic              ex_redirect;
  logic              ex_mdu_start;
  logic              imem_ready;
  logic              mem_access;
  logic              dmem_ready;

  logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic              if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              mdu_valid;
`ifdef HAZ_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_events;
`endif

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_mem_read,
    output exm_rd, exm_reg_write, wb_rd, wb_reg_write,
    output ex_redirect, ex_mdu_start, imem_ready, mem_access, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush,
    input  fwd_a, fwd_b, mdu_valid
`ifdef HAZ_PERF_EN
    , input stall_cycles, flush_events
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_mem_read,
    input  exm_rd, exm_reg_write, wb_rd, wb_reg_write,
    input  ex_redirect, ex_mdu_start, imem_ready, mem_access, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush,
    output fwd_a, fwd_b, mdu_valid
`ifdef HAZ_PERF_EN
    , output stall_cycles, flush_events
`endif
  );

endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand; the youngest producer (EX/MEM) wins over MEM/WB.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_NONE;
    if (exm_reg_write && reg_match(exm_rd, ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && reg_match(wb_rd, ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32 pipeline sequencer: stage enables/flushes, load-use and MDU stalls, redirects,
// memory wait states and EX forwarding selects. HAZ_PERF_EN adds stall/flush event counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hctl_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic dmem_stall;
  logic load_use;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic mdu_valid;

  assign dmem_stall = hif.mem_access & ~hif.dmem_ready;
  assign load_use   = hif.ex_mem_read &
                      ((hif.id_use_rs1 & reg_match(hif.ex_rd, hif.id_rs1)) |
                       (hif.id_use_rs2 & reg_match(hif.ex_rd, hif.id_rs2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A data-memory wait freezes the whole pipe, including the MDU countdown.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!dmem_stall) begin
      case (state_reg)
        RUN: begin
          if (hif.ex_mdu_start) begin
            state_next = (MDU_LATENCY == 1) ? MDU_DONE : MDU_BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
        MDU_BUSY: begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_ONE) begin
            state_next = MDU_DONE;
          end
        end
        MDU_DONE: state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_valid    = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (dmem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if ((state_reg == RUN && hif.ex_mdu_start) || state_reg == MDU_BUSY) begin
      // Hold the front end on the MDU op; bubbles drain towards WB meanwhile.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (state_reg == MDU_DONE) begin
      mdu_valid = 1'b1;
    end else if (hif.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!hif.imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign hif.pc_en        = pc_en;
  assign hif.if_id_en     = if_id_en;
  assign hif.id_ex_en     = id_ex_en;
  assign hif.ex_mem_en    = ex_mem_en;
  assign hif.mem_wb_en    = mem_wb_en;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_flush  = id_ex_flush;
  assign hif.ex_mem_flush = ex_mem_flush;
  assign hif.mdu_valid    = mdu_valid;

  logic [REG_AW-1:0] ex_rs   [2];
  fwd_sel_e          fwd_sel [2];

  assign ex_rs[0] = hif.ex_rs1;
  assign ex_rs[1] = hif.ex_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_unit u_fwd (
      .ex_rs         (ex_rs[gi]),
      .exm_rd        (hif.exm_rd),
      .exm_reg_write (hif.exm_reg_write),
      .wb_rd         (hif.wb_rd),
      .wb_reg_write  (hif.wb_reg_write),
      .sel           (fwd_sel[gi])
    );
  end

  assign hif.fwd_a = rst ? FWD_NONE : fwd_sel[0];
  assign hif.fwd_b = rst ? FWD_NONE : fwd_sel[1];

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_events_reg;
  logic        redirect_win;

  assign redirect_win = (state_reg == RUN) & ~dmem_stall & ~hif.ex_mdu_start & hif.ex_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (!pc_en) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (redirect_win) begin
        flush_events_reg <= flush_events_reg + 32'd1;
      end
    end
  end

  assign hif.stall_cycles = stall_cycles_reg;
  assign hif.flush_events = flush_events_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-count reference model.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: MDU stall cycles still owed after the first, and a pending result cycle.
  int   m_left = 0;
  bit   m_done = 1'b0;

  logic [8:0] last_ctl;
  logic [3:0] last_fwd;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (hif.exm_reg_write && hif.exm_rd != 0 && hif.exm_rd == rs) return 2'b10;
    if (hif.wb_reg_write && hif.wb_rd != 0 && hif.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Order: pc, if_id, id_ex, ex_mem, mem_wb enables; if_id, id_ex, ex_mem flushes; mdu_valid.
  function automatic logic [8:0] ref_ctl();
    bit lu;
    lu = hif.ex_mem_read && hif.ex_rd != 0 &&
         ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) || (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
    if (rst) return 9'b00000_111_0;
    if (hif.mem_access && !hif.dmem_ready) return 9'b00000_000_0;
    if (m_left > 0 || (!m_done && hif.ex_mdu_start)) return 9'b00011_001_0;
    if (m_done) return 9'b11111_000_1;
    if (hif.ex_redirect) return 9'b11111_110_0;
    if (lu) return 9'b00111_010_0;
    if (!hif.imem_ready) return 9'b01111_100_0;
    return 9'b11111_000_0;
  endfunction

  task automatic model_update();
    if (hif.mem_access && !hif.dmem_ready) return;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (hif.ex_mdu_start) begin
      m_left = LAT - 1;
      if (m_left == 0) m_done = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    logic [8:0] exp_ctl;
    logic [3:0] exp_fwd;
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
    end
    @(negedge clk);
    exp_ctl  = ref_ctl();
    exp_fwd  = rst ? 4'b0000 : {ref_fwd(hif.ex_rs1), ref_fwd(hif.ex_rs2)};
    last_ctl = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
                hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush, hif.mdu_valid};
    last_fwd = {hif.fwd_a, hif.fwd_b};
    tests++;
    assert (last_ctl === exp_ctl) else begin
      fails++;
      $error("FAIL %s ctl: got %b expected %b", tag, last_ctl, exp_ctl);
    end
    tests++;
    assert (last_fwd === exp_fwd) else begin
      fails++;
      $error("FAIL %s fwd: got %b expected %b", tag, last_fwd, exp_fwd);
    end
    $display("[TB] %s ctl=%b fwd=%b", tag, last_ctl, last_fwd);
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic set_idle();
    hif.id_rs1 = '0;  hif.id_rs2 = '0;  hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
    hif.ex_rs1 = '0;  hif.ex_rs2 = '0;  hif.ex_rd = '0;        hif.ex_mem_read = 1'b0;
    hif.exm_rd = '0;  hif.exm_reg_write = 1'b0;
    hif.wb_rd = '0;   hif.wb_reg_write = 1'b0;
    hif.ex_redirect = 1'b0; hif.ex_mdu_start = 1'b0;
    hif.imem_ready = 1'b1;  hif.mem_access = 1'b0; hif.dmem_ready = 1'b1;
  endtask

  task automatic set_random();
    hif.id_rs1 = 5'($urandom_range(0, 3)); hif.id_rs2 = 5'($urandom_range(0, 3));
    hif.id_use_rs1 = 1'($urandom_range(0, 1)); hif.id_use_rs2 = 1'($urandom_range(0, 1));
    hif.ex_rs1 = 5'($urandom_range(0, 3)); hif.ex_rs2 = 5'($urandom_range(0, 3));
    hif.ex_rd = 5'($urandom_range(0, 3));  hif.ex_mem_read = 1'($urandom_range(0, 1));
    hif.exm_rd = 5'($urandom_range(0, 3)); hif.exm_reg_write = 1'($urandom_range(0, 1));
    hif.wb_rd = 5'($urandom_range(0, 3));  hif.wb_reg_write = 1'($urandom_range(0, 1));
    hif.ex_redirect  = ($urandom_range(0, 3) == 0);
    hif.ex_mdu_start = ($urandom_range(0, 7) == 0);
    hif.imem_ready   = ($urandom_range(0, 3) != 0);
    hif.mem_access   = ($urandom_range(0, 2) == 0);
    hif.dmem_ready   = ($urandom_range(0, 1) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_stall;
    int  n_valid;
    bit  seen;

    rst = 1'b1;
    set_idle();
    #1;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("post_reset");

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5;
    hif.id_use_rs1 = 1'b1;  hif.id_rs1 = 5'd5;
    hif.id_use_rs2 = 1'b1;  hif.id_rs2 = 5'd1;
    step("loaduse");
    set_idle();
    hif.ex_rs1 = 5'd5; hif.ex_rs2 = 5'd1; hif.wb_rd = 5'd5; hif.wb_reg_write = 1'b1;
    step("loaduse_fwd");
    tests++;
    assert (last_fwd[3:2] === 2'b01) else begin
      fails++;
      $error("FAIL loaduse_fwd_a: got %b expected 01", last_fwd[3:2]);
    end

    // Forwarding priority and x0.
    set_idle();
    hif.exm_rd = 5'd3; hif.exm_reg_write = 1'b1; hif.wb_rd = 5'd3; hif.wb_reg_write = 1'b1;
    hif.ex_rs1 = 5'd3;
    step("fwd_prio");
    tests++;
    assert (last_fwd[3:2] === 2'b10) else begin
      fails++;
      $error("FAIL fwd_prio_a: got %b expected 10", last_fwd[3:2]);
    end
    hif.exm_rd = 5'd0; hif.wb_rd = 5'd0; hif.ex_rs2 = 5'd0;
    step("fwd_x0");
    tests++;
    assert (last_fwd[1:0] === 2'b00) else begin
      fails++;
      $error("FAIL fwd_x0_b: got %b expected 00", last_fwd[1:0]);
    end

    // MDU op with start held through the stall.
    set_idle();
    hif.ex_mdu_start = 1'b1;
    n_stall = 0;
    for (int i = 0; i < LAT; i++) begin
      step("mdu_hold");
      if (last_ctl[8] == 1'b0) n_stall++;
    end
    step("mdu_done");
    tests++;
    assert (last_ctl[0] === 1'b1) else begin
      fails++;
      $error("FAIL mdu_valid: got %b expected 1", last_ctl[0]);
    end
    hif.ex_mdu_start = 1'b0;
    step("mdu_run");
    tests++;
    assert (n_stall === LAT) else begin
      fails++;
      $error("FAIL mdu_stall_len: got %0d expected %0d", n_stall, LAT);
    end

    // Data-memory wait during MDU_BUSY stretches the stall.
    set_idle();
    n_stall = 0;
    hif.ex_mdu_start = 1'b1;
    step("mdu_dm_start");
    if (!last_ctl[8]) n_stall++;
    hif.ex_mdu_start = 1'b0;
    step("mdu_dm_busy");
    if (!last_ctl[8]) n_stall++;
    hif.mem_access = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("mdu_dm_wait");
      if (!last_ctl[8]) n_stall++;
    end
    hif.mem_access = 1'b0; hif.dmem_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step("mdu_dm_drain");
      if (last_ctl[0]) seen = 1'b1;
      else if (!last_ctl[8]) n_stall++;
    end
    tests++;
    assert (seen === 1'b1) else begin
      fails++;
      $error("FAIL mdu_dm_valid: got %b expected 1 within 20 cycles", seen);
    end
    tests++;
    assert (n_stall === LAT + 3) else begin
      fails++;
      $error("FAIL mdu_dm_stall_len: got %0d expected %0d", n_stall, LAT + 3);
    end
    step("mdu_dm_run");

    // Redirect beats load-use and fetch wait.
    set_idle();
    hif.ex_redirect = 1'b1; hif.imem_ready = 1'b0;
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd7; hif.id_use_rs1 = 1'b1; hif.id_rs1 = 5'd7;
    step("redirect_prio");
    tests++;
    assert (last_ctl[8:2] === 7'b11111_11) else begin
      fails++;
      $error("FAIL redirect_prio: got %b expected 1111111", last_ctl[8:2]);
    end

    // Reset in the middle of an MDU stall.
    set_idle();
    hif.ex_mdu_start = 1'b1;
    step("rst_mdu_start");
    hif.ex_mdu_start = 1'b0;
    step("rst_mdu_busy");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    n_valid = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step("rst_after");
      if (last_ctl[0]) n_valid++;
    end
    tests++;
    assert (n_valid === 0) else begin
      fails++;
      $error("FAIL rst_mid_valid: got %0d pulses expected 0", n_valid);
    end

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      set_random();
      rst = ($urandom_range(0, 49) == 0);
      step("rand");
    end
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < LAT + 2; i++) step("tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
